operand_bypass_unit: RTL

//  Parametrised successor of the EXE operand select/forward mux. Picks each of
//  NUM_SRC ALU operands from zero, alternate (PC or imm), or the register value.

---
 rtl/operand_bypass_if.sv | 43 ++++
 rtl/operand_bypass_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/operand_bypass_if.sv
// rtl/operand_bypass_if.sv - issue/forward/ALU bundle for the operand bypass unit
// Purpose: groups every non-clock/reset signal of operand_bypass_unit.
// Ports (master = issue/pipeline side, slave = bypass unit):
//   flush, in_valid/in_ready/in_pc/in_imm/in_sel/in_rs_idx/in_rs_val : issue entry
//   fwd_valid/fwd_rd/fwd_data/fwd_data_ok                             : forwarding stages
//   out_valid/out_ready/out_src                                       : ALU side
//   stall, stall_cnt                                                  : load-use status
interface operand_bypass_if #(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [XLEN-1:0]          in_pc;
  logic [XLEN-1:0]          in_imm;
  logic [2*NUM_SRC-1:0]     in_sel;
  logic [5*NUM_SRC-1:0]     in_rs_idx;
  logic [XLEN*NUM_SRC-1:0]  in_rs_val;
  logic [NUM_FWD-1:0]       fwd_valid;
  logic [5*NUM_FWD-1:0]     fwd_rd;
  logic [XLEN*NUM_FWD-1:0]  fwd_data;
  logic [NUM_FWD-1:0]       fwd_data_ok;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN*NUM_SRC-1:0]  out_src;
  logic                     stall;
  logic [CNT_W-1:0]         stall_cnt;

  modport master (
    output flush, in_valid, in_pc, in_imm, in_sel, in_rs_idx, in_rs_val,
    output fwd_valid, fwd_rd, fwd_data, fwd_data_ok, out_ready,
    input  in_ready, out_valid, out_src, stall, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_pc, in_imm, in_sel, in_rs_idx, in_rs_val,
    input  fwd_valid, fwd_rd, fwd_data, fwd_data_ok, out_ready,
    output in_ready, out_valid, out_src, stall, stall_cnt
  );
endinterface

// File: rtl/operand_bypass_unit.sv
// rtl/operand_bypass_unit.sv - EXE operand select/forward with load-use interlock
// Purpose: resolves NUM_SRC ALU operands from zero, alternate (PC/imm) or register
//   value, overriding register values with the youngest matching forwarding stage.
//   Operands waiting on an in-flight load park in WAIT until their stage reports
//   final data. Result is held in a one-entry valid/ready output register.
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : operand_bypass_if slave modport (issue, forward, ALU, stall status)
module operand_bypass_unit #(
  parameter int XLEN    = 64,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  operand_bypass_if.slave   bus
);

  localparam int PIDX_W = (NUM_FWD > 1) ? $clog2(NUM_FWD) : 1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t                   state;
  logic                     out_valid_q;
  logic                     stall_q;
  logic [CNT_W-1:0]         stall_cnt_q;
  logic [XLEN*NUM_SRC-1:0]  src_q;
  logic [NUM_SRC-1:0]       pend;
  logic [PIDX_W-1:0]        pidx [NUM_SRC];

  logic [XLEN*NUM_SRC-1:0]  res_val;
  logic [NUM_SRC-1:0]       res_pend;
  logic [PIDX_W-1:0]        res_pidx [NUM_SRC];
  logic [NUM_SRC-1:0]       wake;
  logic [NUM_SRC-1:0]       pend_next;
  logic                     in_ready_int;
  logic                     accept;

  // Flush blocks acceptance so nothing slips in on the flush cycle.
  always_comb begin
    in_ready_int = 1'b0;
    case (state)
      S_EMPTY: in_ready_int = 1'b1;
      S_FULL:  in_ready_int = bus.out_ready;
      default: in_ready_int = 1'b0;
    endcase
    in_ready_int = in_ready_int & ~bus.flush;
  end

  assign accept = bus.in_valid & in_ready_int;

  // Operand resolution for the entry being offered this cycle.
  // The stage scan runs oldest to youngest so the youngest match is written last.
  always_comb begin
    res_val  = '0;
    res_pend = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      res_pidx[i] = '0;
      case (bus.in_sel[2*i +: 2])
        2'b01: res_val[i*XLEN +: XLEN] = (i == 0) ? bus.in_pc : bus.in_imm;
        2'b10: begin
          if (bus.in_rs_idx[5*i +: 5] != 5'd0) begin
            res_val[i*XLEN +: XLEN] = bus.in_rs_val[i*XLEN +: XLEN];
            for (int j = NUM_FWD - 1; j >= 0; j--) begin
              if (bus.fwd_valid[j] && (bus.fwd_rd[5*j +: 5] == bus.in_rs_idx[5*i +: 5])) begin
                res_pidx[i] = PIDX_W'(j);
                if (bus.fwd_data_ok[j]) begin
                  res_val[i*XLEN +: XLEN] = bus.fwd_data[j*XLEN +: XLEN];
                  res_pend[i]             = 1'b0;
                end else begin
                  res_val[i*XLEN +: XLEN] = '0;
                  res_pend[i]             = 1'b1;
                end
              end
            end
          end
        end
        default: res_val[i*XLEN +: XLEN] = '0;
      endcase
    end
  end

  // Pending operands whose producing stage now reports final data.
  always_comb begin
    wake = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      wake[i] = pend[i] & bus.fwd_data_ok[pidx[i]];
    end
    pend_next = pend & ~wake;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_EMPTY;
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      src_q       <= '0;
      pend        <= '0;
      for (int i = 0; i < NUM_SRC; i++) pidx[i] <= '0;
    end else if (bus.flush) begin
      state       <= S_EMPTY;
      out_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      pend        <= '0;
    end else begin
      case (state)
        S_EMPTY, S_FULL: begin
          if (accept) begin
            src_q <= res_val;
            pend  <= res_pend;
            for (int i = 0; i < NUM_SRC; i++) pidx[i] <= res_pidx[i];
            if (|res_pend) begin
              state       <= S_WAIT;
              out_valid_q <= 1'b0;
              stall_q     <= 1'b1;
            end else begin
              state       <= S_FULL;
              out_valid_q <= 1'b1;
              stall_q     <= 1'b0;
            end
          end else if ((state == S_FULL) && bus.out_ready) begin
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        S_WAIT: begin
          for (int i = 0; i < NUM_SRC; i++) begin
            if (wake[i]) src_q[i*XLEN +: XLEN] <= bus.fwd_data[pidx[i]*XLEN +: XLEN];
          end
          pend <= pend_next;
          if (pend_next == '0) begin
            state       <= S_FULL;
            out_valid_q <= 1'b1;
            stall_q     <= 1'b0;
          end
        end
        default: begin
          state       <= S_EMPTY;
          out_valid_q <= 1'b0;
          stall_q     <= 1'b0;
        end
      endcase
    end
  end

  // Counts every cycle spent in WAIT, including one that is flushed; saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if ((state == S_WAIT) && !(&stall_cnt_q)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_q;
  assign bus.out_src   = src_q;
  assign bus.stall     = stall_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule
